// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the ALU sequencer.
//   - ALU op codes (6-bit) reused from the 6502 ALU: AND, ADC, SBC.
//   - Sequencer command codes (2-bit): CMD_BIN, CMD_ADC_D, CMD_SBC_D, CMD_ADD16.
//   - is_dec_cmd(): true for the decimal-mode commands.
package alu_seq_pkg;

    localparam logic [5:0] ALU_AND = 6'h00;
    localparam logic [5:0] ALU_ADC = 6'h03;
    localparam logic [5:0] ALU_SBC = 6'h04;

    localparam logic [1:0] CMD_BIN   = 2'd0;
    localparam logic [1:0] CMD_ADC_D = 2'd1;
    localparam logic [1:0] CMD_SBC_D = 2'd2;
    localparam logic [1:0] CMD_ADD16 = 2'd3;

    function automatic logic is_dec_cmd(input logic [1:0] cmd);
        return (cmd == CMD_ADC_D) || (cmd == CMD_SBC_D);
    endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequencer that owns the shared 8-bit ALU.
//   One command is accepted per req handshake; the block then steps the
//   external ALU through one or more passes and presents a 16-bit result
//   plus N/V/Z/C flags on a valid/ready response port.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready command handshake (ready only when idle)
//   req_cmd/op/a/b/ci   command, ALU op (CMD_BIN only), operands, carry in
//   alu_op/ai/bi/ci     drive to the external ALU (combinational per state)
//   alu_out/v/c         ALU result, overflow, carry
//   rsp_valid/rsp_ready response handshake, response held until accepted
//   rsp_data, rsp_n/v/z/c  result and flags
// Parameter DECIMAL_EN=0 runs the decimal commands as plain binary ADC/SBC.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_cmd,
    input  logic [5:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic        req_ci,
    output logic [5:0]  alu_op,
    output logic [7:0]  alu_ai,
    output logic [7:0]  alu_bi,
    output logic        alu_ci,
    input  logic [7:0]  alu_out,
    input  logic        alu_v,
    input  logic        alu_c,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_n,
    output logic        rsp_v,
    output logic        rsp_z,
    output logic        rsp_c
);

    typedef enum logic [2:0] {
        IDLE, BIN, LO, LOFIX, HI, HIFIX, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [5:0]  op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        ci_q, ci_d;
    logic [7:0]  r_q, r_d;        // scratch: pre-fix result, or ADD16 low byte
    logic [3:0]  lo_q, lo_d;      // corrected low BCD digit
    logic        hc_q, hc_d;      // half-carry / half-borrow / ADD16 low carry
    logic        z_bin_q, z_bin_d;
    logic        v_bin_q, v_bin_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_n_q, rsp_n_d;
    logic        rsp_v_q, rsp_v_d;
    logic        rsp_z_q, rsp_z_d;
    logic        rsp_c_q, rsp_c_d;

    logic        is_sub;
    logic        dec_cmd;
    logic [5:0]  dec_op;
    logic        fix_needed;

    assign is_sub  = (cmd_q == CMD_SBC_D);
    assign dec_cmd = DECIMAL_EN && is_dec_cmd(cmd_q);
    assign dec_op  = is_sub ? ALU_SBC : ALU_ADC;

    // A digit needs correction when the add overflowed past 9 (values of
    // 0x10 and above included) or when the subtract borrowed.
    assign fix_needed = is_sub ? !alu_c : (alu_out > 8'd9);

    // ALU drive, decoded from the current state only.
    always_comb begin
        alu_op = ALU_AND;
        alu_ai = 8'h00;
        alu_bi = 8'h00;
        alu_ci = 1'b0;
        case (state_q)
            BIN: begin
                alu_op = (cmd_q == CMD_BIN) ? op_q : dec_op;
                alu_ai = a_q[7:0];
                alu_bi = b_q[7:0];
                alu_ci = ci_q;
            end
            LO: begin
                if (cmd_q == CMD_ADD16) begin
                    alu_op = ALU_ADC;
                    alu_ai = a_q[7:0];
                    alu_bi = b_q[7:0];
                end else begin
                    alu_op = dec_op;
                    alu_ai = {4'h0, a_q[3:0]};
                    alu_bi = {4'h0, b_q[3:0]};
                end
                alu_ci = ci_q;
            end
            HI: begin
                if (cmd_q == CMD_ADD16) begin
                    alu_op = ALU_ADC;
                    alu_ai = a_q[15:8];
                    alu_bi = b_q[15:8];
                    alu_ci = hc_q;
                end else begin
                    alu_op = dec_op;
                    alu_ai = {4'h0, a_q[7:4]};
                    alu_bi = {4'h0, b_q[7:4]};
                    alu_ci = is_sub ? !hc_q : hc_q;
                end
            end
            LOFIX, HIFIX: begin
                // r+6 with no carry, or r-6 with no borrow
                alu_op = dec_op;
                alu_ai = r_q;
                alu_bi = 8'h06;
                alu_ci = is_sub;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        ci_d       = ci_q;
        r_d        = r_q;
        lo_d       = lo_q;
        hc_d       = hc_q;
        z_bin_d    = z_bin_q;
        v_bin_d    = v_bin_q;
        rsp_data_d = rsp_data_q;
        rsp_n_d    = rsp_n_q;
        rsp_v_d    = rsp_v_q;
        rsp_z_d    = rsp_z_q;
        rsp_c_d    = rsp_c_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cmd_d   = req_cmd;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    ci_d    = req_ci;
                    state_d = (req_cmd == CMD_ADD16) ? LO : BIN;
                end
            end
            BIN: begin
                if (dec_cmd) begin
                    // binary pass only contributes Z and V to a decimal result
                    z_bin_d = (alu_out == 8'h00);
                    v_bin_d = alu_v;
                    state_d = LO;
                end else begin
                    rsp_data_d = {8'h00, alu_out};
                    rsp_n_d    = alu_out[7];
                    rsp_z_d    = (alu_out == 8'h00);
                    rsp_v_d    = alu_v;
                    rsp_c_d    = alu_c;
                    state_d    = DONE;
                end
            end
            LO: begin
                if (cmd_q == CMD_ADD16) begin
                    r_d     = alu_out;
                    hc_d    = alu_c;
                    state_d = HI;
                end else if (fix_needed) begin
                    r_d     = alu_out;
                    state_d = LOFIX;
                end else begin
                    lo_d    = alu_out[3:0];
                    hc_d    = 1'b0;
                    state_d = HI;
                end
            end
            LOFIX: begin
                lo_d    = alu_out[3:0];
                hc_d    = 1'b1;
                state_d = HI;
            end
            HI: begin
                if (cmd_q == CMD_ADD16) begin
                    rsp_data_d = {alu_out, r_q};
                    rsp_n_d    = alu_out[7];
                    rsp_z_d    = ({alu_out, r_q} == 16'h0000);
                    rsp_v_d    = alu_v;
                    rsp_c_d    = alu_c;
                    state_d    = DONE;
                end else if (fix_needed) begin
                    r_d     = alu_out;
                    state_d = HIFIX;
                end else begin
                    rsp_data_d = {8'h00, alu_out[3:0], lo_q};
                    rsp_n_d    = alu_out[3];
                    rsp_z_d    = z_bin_q;
                    rsp_v_d    = v_bin_q;
                    rsp_c_d    = alu_c;
                    state_d    = DONE;
                end
            end
            HIFIX: begin
                rsp_data_d = {8'h00, alu_out[3:0], lo_q};
                rsp_n_d    = alu_out[3];
                rsp_z_d    = z_bin_q;
                rsp_v_d    = v_bin_q;
                // a corrected high digit means decimal carry out (ADC)
                // or decimal borrow out (SBC)
                rsp_c_d    = !is_sub;
                state_d    = DONE;
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= CMD_BIN;
            op_q        <= ALU_AND;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            ci_q        <= 1'b0;
            r_q         <= 8'h00;
            lo_q        <= 4'h0;
            hc_q        <= 1'b0;
            z_bin_q     <= 1'b0;
            v_bin_q     <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_n_q     <= 1'b0;
            rsp_v_q     <= 1'b0;
            rsp_z_q     <= 1'b0;
            rsp_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ci_q        <= ci_d;
            r_q         <= r_d;
            lo_q        <= lo_d;
            hc_q        <= hc_d;
            z_bin_q     <= z_bin_d;
            v_bin_q     <= v_bin_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_n_q     <= rsp_n_d;
            rsp_v_q     <= rsp_v_d;
            rsp_z_q     <= rsp_z_d;
            rsp_c_q     <= rsp_c_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_n     = rsp_n_q;
    assign rsp_v     = rsp_v_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_c     = rsp_c_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural 8-bit ALU next to
// each sequencer instance (DECIMAL_EN=1 and DECIMAL_EN=0).
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam logic [5:0] ALU_ORA = 6'h01;
    localparam logic [5:0] ALU_EOR = 6'h02;

    typedef struct {
        logic [15:0] data;
        logic        n, v, z, c;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid0;
    logic        req_ready, req_ready0;
    logic [1:0]  req_cmd;
    logic [5:0]  req_op;
    logic [15:0] req_a, req_b;
    logic        req_ci;
    logic        rsp_ready;
    logic        rsp_ready0;
    logic [5:0]  alu_op, alu_op0;
    logic [7:0]  alu_ai, alu_bi, alu_ai0, alu_bi0;
    logic        alu_ci, alu_ci0;
    logic [7:0]  alu_out, alu_out0;
    logic        alu_v, alu_c, alu_v0, alu_c0;
    logic        rsp_valid, rsp_valid0;
    logic [15:0] rsp_data, rsp_data0;
    logic        rsp_n, rsp_v, rsp_z, rsp_c;
    logic        rsp_n0, rsp_v0, rsp_z0, rsp_c0;

    int nvec  = 0;
    int nfail = 0;
    int cyc   = 0;
    int rsp_cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural ALU shared by both instances
    function automatic logic [9:0] alu_f(input logic [5:0] op, input logic [7:0] ai,
                                         input logic [7:0] bi, input logic ci);
        logic [8:0] s;
        logic [7:0] o;
        logic       c, v;
        o = 8'h00; c = 1'b0; v = 1'b0; s = 9'h000;
        case (op)
            ALU_AND: o = ai & bi;
            ALU_ORA: o = ai | bi;
            ALU_EOR: o = ai ^ bi;
            ALU_ADC: begin
                s = {1'b0, ai} + {1'b0, bi} + {8'h00, ci};
                o = s[7:0]; c = s[8];
                v = ~(ai[7] ^ bi[7]) & (ai[7] ^ o[7]);
            end
            ALU_SBC: begin
                s = {1'b0, ai} + {1'b0, ~bi} + {8'h00, ci};
                o = s[7:0]; c = s[8];
                v = (ai[7] ^ bi[7]) & (ai[7] ^ o[7]);
            end
            default: ;
        endcase
        return {v, c, o};
    endfunction

    assign {alu_v,  alu_c,  alu_out}  = alu_f(alu_op,  alu_ai,  alu_bi,  alu_ci);
    assign {alu_v0, alu_c0, alu_out0} = alu_f(alu_op0, alu_ai0, alu_bi0, alu_ci0);

    alu_seq #(.DECIMAL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .alu_op(alu_op), .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
        .alu_out(alu_out), .alu_v(alu_v), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_n(rsp_n), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_c(rsp_c)
    );

    alu_seq #(.DECIMAL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_cmd(req_cmd), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_ci(req_ci),
        .alu_op(alu_op0), .alu_ai(alu_ai0), .alu_bi(alu_bi0), .alu_ci(alu_ci0),
        .alu_out(alu_out0), .alu_v(alu_v0), .alu_c(alu_c0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_data(rsp_data0),
        .rsp_n(rsp_n0), .rsp_v(rsp_v0), .rsp_z(rsp_z0), .rsp_c(rsp_c0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nfail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Binary 8-bit result with integer arithmetic: {v, c, res}
    function automatic logic [9:0] bin_model(input logic [5:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic ci);
        int ua, ub, sa, sb, r, s;
        logic [7:0] o;
        logic c, v;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        o = 8'h00; c = 1'b0; v = 1'b0;
        if (op == ALU_ADC) begin
            r = ua + ub + (ci ? 1 : 0);
            s = sa + sb + (ci ? 1 : 0);
            o = r[7:0]; c = (r > 255); v = (s > 127) || (s < -128);
        end else if (op == ALU_SBC) begin
            r = ua - ub - (ci ? 0 : 1);
            s = sa - sb - (ci ? 0 : 1);
            o = r[7:0]; c = (r >= 0); v = (s > 127) || (s < -128);
        end else if (op == ALU_AND) o = a & b;
        else if (op == ALU_ORA) o = a | b;
        else if (op == ALU_EOR) o = a ^ b;
        return {v, c, o};
    endfunction

    function automatic exp_t model(input logic [1:0] cmd, input logic [5:0] op,
                                   input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input bit decen);
        exp_t e;
        logic [9:0] bm;
        logic [5:0] eop;
        int lo, hi, al, bl, ah, bh, sa, sb, s, r;
        bit fl, fh;
        e.acc = 0;
        if (cmd == CMD_ADD16) begin
            r = int'(a) + int'(b) + (ci ? 1 : 0);
            sa = $signed(a); sb = $signed(b);
            s = sa + sb + (ci ? 1 : 0);
            e.data = r[15:0];
            e.c = (r > 65535);
            e.v = (s > 32767) || (s < -32768);
            e.n = e.data[15];
            e.z = (e.data == 16'h0000);
            e.lat = 3;
        end else if (cmd == CMD_BIN || !decen) begin
            eop = (cmd == CMD_BIN) ? op : ((cmd == CMD_SBC_D) ? ALU_SBC : ALU_ADC);
            bm = bin_model(eop, a[7:0], b[7:0], ci);
            e.data = {8'h00, bm[7:0]};
            e.c = bm[8]; e.v = bm[9];
            e.n = bm[7]; e.z = (bm[7:0] == 8'h00);
            e.lat = 2;
        end else begin
            bm = bin_model((cmd == CMD_SBC_D) ? ALU_SBC : ALU_ADC, a[7:0], b[7:0], ci);
            e.v = bm[9];
            e.z = (bm[7:0] == 8'h00);
            al = a[3:0]; bl = b[3:0]; ah = a[7:4]; bh = b[7:4];
            if (cmd == CMD_ADC_D) begin
                lo = al + bl + (ci ? 1 : 0);
                fl = (lo > 9);
                if (fl) lo = lo + 6;
                hi = ah + bh + (fl ? 1 : 0);
                fh = (hi > 9);
                if (fh) hi = hi + 6;
                e.c = fh;
            end else begin
                lo = al - bl - (ci ? 0 : 1);
                fl = (lo < 0);
                if (fl) lo = lo - 6;
                hi = ah - bh - (fl ? 1 : 0);
                fh = (hi < 0);
                if (fh) hi = hi - 6;
                e.c = !fh;
            end
            e.data = {8'h00, hi[3:0], lo[3:0]};
            e.n = e.data[7];
            e.lat = 4 + (fl ? 1 : 0) + (fh ? 1 : 0);
        end
        return e;
    endfunction

    // compare process for the DECIMAL_EN=1 instance
    logic        active = 1'b0;
    logic [19:0] hold;
    exp_t        cur;
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid) begin
                if (!active) begin
                    active = 1'b1;
                    rsp_cnt++;
                    hold = {rsp_data, rsp_n, rsp_v, rsp_z, rsp_c};
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", {16'h0, rsp_data}, 32'hFFFF_FFFF);
                    end else begin
                        cur = q.pop_front();
                        chk("rsp_data", {16'h0, rsp_data}, {16'h0, cur.data});
                        chk("rsp_nvzc", {28'h0, rsp_n, rsp_v, rsp_z, rsp_c},
                            {28'h0, cur.n, cur.v, cur.z, cur.c});
                        chk("latency", cyc - cur.acc + 1, cur.lat);
                    end
                end else begin
                    chk("rsp_stable", {12'h0, rsp_n, rsp_v, rsp_z, rsp_c, rsp_data},
                        {12'h0, hold[3:0], hold[19:4]});
                end
                chk("ready_low_in_done", {31'h0, req_ready}, 32'h0);
            end else begin
                active = 1'b0;
                if (req_ready)
                    chk("idle_alu_drive", {16'h0, 2'b0, alu_op, alu_ai ^ alu_bi, 7'h0, alu_ci},
                        {16'h0, 2'b0, ALU_AND, 8'h00, 8'h00});
            end
        end
    end

    task automatic issue(input logic [1:0] cmd, input logic [5:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ci);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("ready_timeout");
        req_cmd = cmd; req_op = op; req_a = a; req_b = b; req_ci = ci;
        req_valid = 1'b1;
        e = model(cmd, op, a, b, ci, 1'b1);
        @(posedge clk);
        #1;
        e.acc = cyc;
        q.push_back(e);
        // scramble inputs to show they are latched at acceptance
        req_valid = 1'b0;
        req_a = ~a; req_b = 16'h5A5A; req_ci = ~ci; req_cmd = CMD_BIN; req_op = ALU_EOR;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!(req_ready && q.size() == 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(req_ready && q.size() == 0)) fail_now("done_timeout");
    endtask

    task automatic run1(input logic [1:0] cmd, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ci);
        issue(cmd, op, a, b, ci);
        wait_done();
    endtask

    task automatic run0(input logic [1:0] cmd, input logic [5:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic ci, input logic [15:0] lit);
        exp_t e;
        int n, acc;
        e = model(cmd, op, a, b, ci, 1'b0);
        @(negedge clk);
        req_cmd = cmd; req_op = op; req_a = a; req_b = b; req_ci = ci;
        req_valid0 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid0 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rsp_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid0) fail_now("bin_only_timeout");
        else begin
            chk("bin_only_data", {16'h0, rsp_data0}, {16'h0, e.data});
            chk("bin_only_literal", {16'h0, rsp_data0}, {16'h0, lit});
            chk("bin_only_flags", {28'h0, rsp_n0, rsp_v0, rsp_z0, rsp_c0},
                {28'h0, e.n, e.v, e.z, e.c});
            chk("bin_only_latency", cyc - acc + 1, 2);
        end
        @(negedge clk);
        chk("bin_only_ready", {31'h0, req_ready0}, 32'h1);
    endtask

    exp_t m;
    int   n;
    int   snap;
    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_valid0 = 1'b0;
        req_cmd = CMD_BIN; req_op = ALU_AND; req_a = 16'h0; req_b = 16'h0; req_ci = 1'b0;
        rsp_ready = 1'b1; rsp_ready0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", {30'h0, req_ready, req_ready0}, 32'h3);
        chk("reset_valid", {30'h0, rsp_valid, rsp_valid0}, 32'h0);
        chk("reset_data_flags", {12'h0, rsp_data, rsp_n, rsp_v, rsp_z, rsp_c}, 32'h0);
        chk("reset_alu_drive", {9'h0, alu_op, alu_ai, alu_bi, alu_ci}, {9'h0, ALU_AND, 17'h0});
        rst = 1'b0;

        // pin the model against hand-computed results
        m = model(CMD_ADC_D, ALU_AND, 16'h0058, 16'h0046, 1'b0, 1'b1);
        chk("model_adcd", {m.data, 8'h0, m.n, m.v, m.z, m.c, m.lat[3:0]}, {16'h0004, 8'h0, 4'b0101, 4'd6});
        m = model(CMD_SBC_D, ALU_AND, 16'h0012, 16'h0021, 1'b1, 1'b1);
        chk("model_sbcd", {m.data, 12'h0, m.c, m.lat[2:0]}, {16'h0091, 12'h0, 1'b0, 3'd5});
        m = model(CMD_ADD16, ALU_AND, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        chk("model_add16", {m.data, 14'h0, m.z, m.c}, {16'h0000, 14'h0, 2'b11});

        run1(CMD_ADC_D, ALU_AND, 16'h0058, 16'h0046, 1'b0);
        run1(CMD_SBC_D, ALU_AND, 16'h0046, 16'h0012, 1'b1);
        run1(CMD_SBC_D, ALU_AND, 16'h0012, 16'h0021, 1'b1);
        run1(CMD_ADD16, ALU_AND, 16'h12FF, 16'h0001, 1'b0);
        run1(CMD_ADD16, ALU_AND, 16'hFFFF, 16'h0001, 1'b0);
        run1(CMD_BIN,   ALU_AND, 16'h00F0, 16'h000F, 1'b0);
        run1(CMD_BIN,   ALU_ADC, 16'h007F, 16'h0001, 1'b0);
        run1(CMD_BIN,   ALU_SBC, 16'h0000, 16'h0001, 1'b1);
        run1(CMD_BIN,   ALU_EOR, 16'h00FF, 16'h000F, 1'b0);
        run1(CMD_ADC_D, ALU_AND, 16'h0099, 16'h0001, 1'b0);
        run1(CMD_ADC_D, ALU_AND, 16'h0015, 16'h0027, 1'b1);
        run1(CMD_ADC_D, ALU_AND, 16'h0099, 16'h0099, 1'b0);
        run1(CMD_SBC_D, ALU_AND, 16'h0000, 16'h0001, 1'b1);
        run1(CMD_SBC_D, ALU_AND, 16'h0012, 16'h0012, 1'b1);
        run1(CMD_ADD16, ALU_AND, 16'h7FFF, 16'h0000, 1'b1);

        // binary-only instance
        run0(CMD_BIN,   ALU_AND, 16'h00F0, 16'h000F, 1'b0, 16'h0000);
        run0(CMD_ADC_D, ALU_AND, 16'h0009, 16'h0001, 1'b0, 16'h000A);
        run0(CMD_SBC_D, ALU_AND, 16'h0010, 16'h0001, 1'b1, 16'h000F);

        // backpressure: response held for 10 cycles, new requests ignored
        rsp_ready = 1'b0;
        issue(CMD_ADD16, ALU_AND, 16'h1234, 16'h1111, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) fail_now("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_cmd = CMD_BIN; req_op = ALU_EOR;
            req_a = 16'(i); req_b = 16'h00FF;
        end
        @(negedge clk);
        chk("bp_data_held", {16'h0, rsp_data}, 32'h2345);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done();

        // reset while in the high-byte pass abandons the command
        snap = rsp_cnt;
        issue(CMD_ADD16, ALU_AND, 16'h1234, 16'h0101, 1'b0);
        @(negedge clk);
        chk("lo_alu_drive", {14'h0, alu_ai, alu_bi, alu_ci, alu_op == ALU_ADC}, {14'h0, 8'h34, 8'h01, 2'b01});
        @(negedge clk);
        chk("hi_alu_drive", {14'h0, alu_ai, alu_bi, alu_ci, alu_op == ALU_ADC}, {14'h0, 8'h12, 8'h01, 2'b01});
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_mid_alu", {9'h0, alu_op, alu_ai, alu_bi, alu_ci}, {9'h0, ALU_AND, 17'h0});
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_no_response", rsp_cnt, snap);
        chk("rst_idle_ready", {31'h0, req_ready}, 32'h1);

        run1(CMD_ADC_D, ALU_AND, 16'h0058, 16'h0046, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle sequencer that owns the shared 8-bit ALU.
- Accepts one arithmetic command per handshake and drives the ALU op, operand and carry ports cycle by cycle.
- Covers three operation classes:
  - single-pass binary ops;
  - NMOS-style decimal-mode ADC/SBC, built from nibble passes plus correction passes;
  - 16-bit add, built as a low-byte pass then a high-byte pass.
- Sits between the CPU control unit and the ALU. The ALU is instantiated by the parent, not inside this block.

Parameters:
- DECIMAL_EN, 1, when 0 the decimal commands execute as their binary equivalents (BIN with ALU_ADC / ALU_SBC).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  command request
- req_ready  out  1  block idle, able to accept
- req_cmd  in  2  CMD_BIN / CMD_ADC_D / CMD_SBC_D / CMD_ADD16
- req_op  in  6  ALU op code, used by CMD_BIN only
- req_a  in  16  operand A (8-bit commands use [7:0])
- req_b  in  16  operand B
- req_ci  in  1  carry in
- alu_op  out  6  to ALU op
- alu_ai  out  8  to ALU ai
- alu_bi  out  8  to ALU bi
- alu_ci  out  1  to ALU ci
- alu_out  in  8  ALU result
- alu_v  in  1  ALU overflow
- alu_c  in  1  ALU carry
- rsp_valid  out  1  result valid, held until accepted
- rsp_ready  in  1  result accepted
- rsp_data  out  16  result; [15:8]=0 for 8-bit commands
- rsp_n, rsp_v, rsp_z, rsp_c  out  1 each  result flags

Behaviour:

Reset and handshake
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, all flags 0, alu_op=ALU_AND, alu_ai=alu_bi=0, alu_ci=0.
- Reset is asynchronous; reset mid-command abandons the command with no response.
- Command accepted on a rising edge with req_valid&&req_ready. Operands are latched at that edge; later changes on req_* are ignored.
- req_ready=1 only in IDLE.

State machine and per-state ALU drive
- States: IDLE, BIN, LO, LOFIX, HI, HIFIX, DONE. Each compute state lasts exactly 1 cycle, drives the ALU combinationally and registers alu_out / alu_c / alu_v at its end.
- Outside compute states the ALU ports are driven to their reset values.
- BIN:
  - CMD_BIN: alu_op=req_op, ai=a[7:0], bi=b[7:0], ci=req_ci.
  - Decimal commands: binary ALU_ADC / ALU_SBC pass; Z and V are captured here.
- LO:
  - CMD_ADC_D / CMD_SBC_D: ALU_ADC / ALU_SBC on zero-extended low nibbles, ci=req_ci.
  - CMD_ADD16: ALU_ADC on a[7:0], b[7:0], ci=req_ci.
- LOFIX: entered only when the fix is needed.
  - ADC: entered when the LO result > 9. Drives ALU_ADC r+6, ci=0; lo=out[3:0]; half-carry=1.
  - SBC: entered when LO alu_c=0 (borrow). Drives ALU_SBC r-6, ci=1; lo=out[3:0]; half-borrow=1.
  - Otherwise lo=r[3:0] and half-carry/half-borrow=0.
- HI:
  - Decimal commands: high nibbles, ci=half-carry (ADC) or !half-borrow (SBC).
  - CMD_ADD16: ALU_ADC on [15:8], ci=LO alu_c.
- HIFIX: same rule as LOFIX, applied to the high nibble.
  - C=1 if fixed (ADC) and C=0 if fixed (SBC); otherwise C comes from the HI pass.
  - Values ≥0x10 before the fix are treated as >9.

Sequences and latency (edges after acceptance to rsp_valid)
- CMD_BIN: IDLE→BIN→DONE; 2.
- Decimal commands: BIN→LO→[LOFIX]→HI→[HIFIX]→DONE; 4 to 6.
- CMD_ADD16: LO→HI→DONE; 3.
- With DECIMAL_EN=0, decimal commands use the BIN sequence.

Result flags
- CMD_BIN: C, V from the ALU; N=out[7]; Z=(out==0).
- Decimal commands: Z, V from the binary pass; N=final[7]; C from the decimal passes.
- CMD_ADD16: C, V from the HI pass; N=res[15]; Z=(res==0).

DONE state
- rsp_valid=1; rsp_* held stable while rsp_ready=0.
- On rsp_ready, go to IDLE; req_ready rises the following cycle.

Decomposition:
- Shared 6502 defines header gains the CMD_* codes (2-bit). Existing ALU_ADC / ALU_SBC / ALU_AND constants are reused.
- State enum is local to the module.
- No sub-module. Nibble >9 compare and flag logic stay inline.
- Bench instantiates alu alongside alu_seq.

Test Plan:
- Decimal add: CMD_ADC_D a=0x58 b=0x46 ci=0.
  - Response: rsp_data=0x0004, C=1, Z=0, V=1 (binary 0x9E), N=0.
  - Both fix states visited; rsp_valid 6 edges after accept.
- Decimal sub, no fix: CMD_SBC_D a=0x46 b=0x12 ci=1 → 0x0034, C=1; 4-edge latency.
- Decimal sub with borrow: CMD_SBC_D a=0x12 b=0x21 ci=1 → 0x0091, C=0; HIFIX visited, LOFIX skipped.
- 16-bit add:
  - CMD_ADD16 0x12FF+0x0001 ci=0 → 0x1300, C=0, Z=0.
  - 0xFFFF+0x0001 → 0x0000, C=1, Z=1.
- CMD_BIN ALU_AND 0xF0,0x0F → 0x00, Z=1, 2-edge latency. Repeat with DECIMAL_EN=0 and CMD_ADC_D 0x09+0x01 → 0x0A.
- Backpressure and reset:
  - Hold rsp_ready=0 for 10 cycles: rsp stable, req_ready=0, new req_valid ignored.
  - Assert rst during HI: immediate IDLE, rsp_valid=0, no response emitted.
